// File: rtl/sound_sequencer_pkg.sv
// Shared clip identifiers, request-bit indices and the clip priority ranking
// used by the sound sequencer and its priority encoder.
package sound_sequencer_pkg;

    // Clip codes equal their request-bit index, so a code doubles as a bit position.
    typedef enum logic [2:0] {
        SOUND_LOADING   = 3'd0,
        SOUND_READY     = 3'd1,
        SOUND_WIN       = 3'd2,
        SOUND_GAME_PLAY = 3'd3,
        SOUND_FAIL      = 3'd4
    } sound_t;

    localparam int REQ_LOADING   = 0;
    localparam int REQ_READY     = 1;
    localparam int REQ_WIN       = 2;
    localparam int REQ_GAME_PLAY = 3;
    localparam int REQ_FAIL      = 4;
    localparam int NUM_SOUNDS    = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_GAP
    } seq_state_t;

    // Larger rank wins: FAIL > LOADING > READY > WIN > GAME_PLAY.
    function automatic logic [2:0] sound_rank(input sound_t s);
        case (s)
            SOUND_FAIL:      return 3'd4;
            SOUND_LOADING:   return 3'd3;
            SOUND_READY:     return 3'd2;
            SOUND_WIN:       return 3'd1;
            default:         return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Picks the highest-priority clip from a one-bit-per-clip request vector.
module sound_prio_enc
    import sound_sequencer_pkg::*;
(
    input  logic [NUM_SOUNDS-1:0] bits,
    output sound_t                top,
    output logic                  valid
);

    always_comb begin
        top   = SOUND_LOADING;
        valid = |bits;
        if (bits[REQ_FAIL])
            top = SOUND_FAIL;
        else if (bits[REQ_LOADING])
            top = SOUND_LOADING;
        else if (bits[REQ_READY])
            top = SOUND_READY;
        else if (bits[REQ_WIN])
            top = SOUND_WIN;
        else if (bits[REQ_GAME_PLAY])
            top = SOUND_GAME_PLAY;
    end

endmodule

// File: rtl/sound_sequencer.sv
// One-shot clip scheduler: queues requests, plays the highest-priority clip,
// inserts a silence gap between clips and reports natural completion.
module sound_sequencer
    import sound_sequencer_pkg::*;
#(
    parameter int unsigned INTRO_LEN = 12280,
    parameter int unsigned CHOMP_LEN = 5736,
    parameter int unsigned DEATH_LEN = 33736,
    parameter int unsigned WIN_LEN   = 12280,
    parameter int unsigned GAP_TICKS = 400
) (
    input  logic                  clk_25MHZ,
    input  logic                  rst,
    input  logic                  clk_8KHZ,
    input  logic [NUM_SOUNDS-1:0] req,
    input  logic                  stop,
    output sound_t                sound_type,
    output logic [15:0]           addr,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  done
);

    seq_state_t            state_reg, state_next;
    logic [NUM_SOUNDS-1:0] pending_reg, pending_next;
    sound_t                cur_reg, cur_next;
    logic [15:0]           last_reg, last_next;
    logic [15:0]           addr_reg, addr_next;
    logic [15:0]           gap_cnt_reg, gap_cnt_next;
    logic                  done_reg, done_next;
    logic                  sample_valid_reg, sample_valid_next;
    logic                  busy_reg, busy_next;

    sound_t pend_top, req_top;
    logic   pend_valid, req_valid;
    logic   preempt;

    sound_prio_enc u_pend_enc (
        .bits  (pending_reg),
        .top   (pend_top),
        .valid (pend_valid)
    );

    sound_prio_enc u_req_enc (
        .bits  (req),
        .top   (req_top),
        .valid (req_valid)
    );

    // Stored as length-1 so a 65536-sample clip still fits the 16-bit address.
    function automatic logic [15:0] clip_last(input sound_t s);
        case (s)
            SOUND_GAME_PLAY: return 16'(CHOMP_LEN - 1);
            SOUND_FAIL:      return 16'(DEATH_LEN - 1);
            SOUND_WIN:       return 16'(WIN_LEN - 1);
            default:         return 16'(INTRO_LEN - 1);
        endcase
    endfunction

    assign preempt = req_valid && (sound_rank(req_top) > sound_rank(cur_reg));

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg | req;
        cur_next     = cur_reg;
        last_next    = last_reg;
        addr_next    = addr_reg;
        gap_cnt_next = gap_cnt_reg;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pend_valid)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (pend_valid) begin
                    cur_next     = pend_top;
                    last_next    = clip_last(pend_top);
                    pending_next = (pending_reg & ~(NUM_SOUNDS'(1) << pend_top)) | req;
                    addr_next    = 16'd0;
                    state_next   = ST_PLAY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // A natural end wins over a same-cycle preemption so done and the gap are kept.
                if (clk_8KHZ && addr_reg == last_reg) begin
                    done_next    = 1'b1;
                    gap_cnt_next = 16'd0;
                    state_next   = ST_GAP;
                end else if (preempt) begin
                    state_next = ST_LOAD;
                end else if (clk_8KHZ) begin
                    addr_next = addr_reg + 16'd1;
                end
            end
            ST_GAP: begin
                if (preempt) begin
                    state_next = ST_LOAD;
                end else if (clk_8KHZ) begin
                    if (gap_cnt_reg == 16'(GAP_TICKS - 1))
                        state_next = (pending_next != '0) ? ST_LOAD : ST_IDLE;
                    else
                        gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (stop) begin
            state_next   = ST_IDLE;
            pending_next = '0;
            addr_next    = 16'd0;
            done_next    = 1'b0;
        end

        sample_valid_next = (state_next == ST_PLAY);
        busy_next         = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk_25MHZ) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            pending_reg      <= '0;
            cur_reg          <= SOUND_LOADING;
            last_reg         <= 16'd0;
            addr_reg         <= 16'd0;
            gap_cnt_reg      <= 16'd0;
            done_reg         <= 1'b0;
            sample_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            pending_reg      <= pending_next;
            cur_reg          <= cur_next;
            last_reg         <= last_next;
            addr_reg         <= addr_next;
            gap_cnt_reg      <= gap_cnt_next;
            done_reg         <= done_next;
            sample_valid_reg <= sample_valid_next;
            busy_reg         <= busy_next;
        end
    end

    assign sound_type   = cur_reg;
    assign addr         = addr_reg;
    assign sample_valid = sample_valid_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed checks of the sound sequencer: playback, priority, preemption,
// queuing, stop, end-of-clip request and reset.
module tb_sound_sequencer;
    import sound_sequencer_pkg::*;

    logic        clk_25MHZ = 1'b0;
    logic        rst       = 1'b1;
    logic        clk_8KHZ  = 1'b0;
    logic [4:0]  req       = 5'd0;
    logic        stop      = 1'b0;
    sound_t      sound_type;
    logic [15:0] addr;
    logic        sample_valid;
    logic        busy;
    logic        done;

    int tests    = 0;
    int failed   = 0;
    int done_cnt = 0;

    sound_sequencer #(
        .INTRO_LEN (3),
        .CHOMP_LEN (4),
        .DEATH_LEN (5),
        .WIN_LEN   (3),
        .GAP_TICKS (2)
    ) dut (
        .clk_25MHZ    (clk_25MHZ),
        .rst          (rst),
        .clk_8KHZ     (clk_8KHZ),
        .req          (req),
        .stop         (stop),
        .sound_type   (sound_type),
        .addr         (addr),
        .sample_valid (sample_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk_25MHZ = ~clk_25MHZ;

    typedef struct {
        logic [4:0] r;
        logic       stb;
        int         busy;
        int         sv;
        int         dn;
        int         addr;
        int         st;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0d", name, act);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic cyc(input logic [4:0] r, input logic s, input logic stb);
        @(negedge clk_25MHZ);
        req      = r;
        stop     = s;
        clk_8KHZ = stb;
        @(posedge clk_25MHZ);
        #1;
        if (done) done_cnt++;
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) cyc(5'd0, 1'b0, 1'b1);
    endtask

    initial begin
        // req=GAME_PLAY; strobes during IDLE->LOAD and LOAD->PLAY must be ignored.
        vecs[0]  = '{5'd8, 1'b0, 0, 0, 0, 0, 0};
        vecs[1]  = '{5'd0, 1'b1, 1, 0, 0, 0, 0};
        vecs[2]  = '{5'd0, 1'b1, 1, 1, 0, 0, 3};
        vecs[3]  = '{5'd0, 1'b1, 1, 1, 0, 1, 3};
        vecs[4]  = '{5'd0, 1'b0, 1, 1, 0, 1, 3};
        vecs[5]  = '{5'd0, 1'b1, 1, 1, 0, 2, 3};
        vecs[6]  = '{5'd0, 1'b1, 1, 1, 0, 3, 3};
        vecs[7]  = '{5'd0, 1'b1, 1, 0, 1, 3, 3};
        vecs[8]  = '{5'd0, 1'b0, 1, 0, 0, 3, 3};
        vecs[9]  = '{5'd0, 1'b1, 1, 0, 0, 3, 3};
        vecs[10] = '{5'd0, 1'b1, 0, 0, 0, 3, 3};
        vecs[11] = '{5'd0, 1'b1, 0, 0, 0, 3, 3};

        // Reset state
        cyc(5'd0, 1'b0, 1'b0);
        cyc(5'd0, 1'b0, 1'b1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sv", int'(sample_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_type", int'(sound_type), int'(SOUND_LOADING));
        rst = 1'b0;

        // Single chomp, table driven
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].r, 1'b0, vecs[i].stb);
            chk($sformatf("v%0d_busy", i), int'(busy), vecs[i].busy);
            chk($sformatf("v%0d_sv", i), int'(sample_valid), vecs[i].sv);
            chk($sformatf("v%0d_done", i), int'(done), vecs[i].dn);
            chk($sformatf("v%0d_addr", i), int'(addr), vecs[i].addr);
            chk($sformatf("v%0d_type", i), int'(sound_type), vecs[i].st);
        end

        // READY and GAME_PLAY together: READY first
        cyc(5'b01010, 1'b0, 1'b0);
        cyc(5'd0, 1'b0, 1'b0);
        cyc(5'd0, 1'b0, 1'b0);
        chk("prio_type_ready", int'(sound_type), int'(SOUND_READY));
        chk("prio_sv", int'(sample_valid), 1);
        chk("prio_addr0", int'(addr), 0);
        strobes(2);
        chk("prio_addr2", int'(addr), 2);
        strobes(1);
        chk("prio_ready_done", int'(done), 1);
        strobes(2);
        chk("prio_load_busy", int'(busy), 1);
        chk("prio_load_sv", int'(sample_valid), 0);
        cyc(5'd0, 1'b0, 1'b0);
        chk("prio_type_chomp", int'(sound_type), int'(SOUND_GAME_PLAY));
        chk("prio_chomp_addr0", int'(addr), 0);

        // FAIL preempts chomp at addr 2
        done_cnt = 0;
        strobes(2);
        chk("pre_addr2", int'(addr), 2);
        cyc(5'd16, 1'b0, 1'b0);
        chk("pre_load_busy", int'(busy), 1);
        chk("pre_load_sv", int'(sample_valid), 0);
        chk("pre_load_done", int'(done), 0);
        cyc(5'd0, 1'b0, 1'b0);
        chk("pre_type_fail", int'(sound_type), int'(SOUND_FAIL));
        chk("pre_fail_addr0", int'(addr), 0);

        // Three chomp requests during FAIL queue a single replay
        cyc(5'd8, 1'b0, 1'b1);
        cyc(5'd8, 1'b0, 1'b1);
        cyc(5'd8, 1'b0, 1'b0);
        chk("q_fail_addr2", int'(addr), 2);
        strobes(3);
        chk("q_fail_done", int'(done), 1);
        strobes(2);
        cyc(5'd0, 1'b0, 1'b0);
        chk("q_type_chomp", int'(sound_type), int'(SOUND_GAME_PLAY));
        chk("q_chomp_sv", int'(sample_valid), 1);
        strobes(4);
        chk("q_chomp_done", int'(done), 1);
        strobes(2);
        for (int k = 0; k < 4; k++) cyc(5'd0, 1'b0, 1'b1);
        chk("q_idle_busy", int'(busy), 0);
        chk("q_done_count", done_cnt, 2);
        chk("q_pending_empty", int'(dut.pending_reg), 0);

        // stop together with FAIL request during PLAY
        done_cnt = 0;
        cyc(5'd8, 1'b0, 1'b0);
        cyc(5'd0, 1'b0, 1'b0);
        cyc(5'd0, 1'b0, 1'b1);
        cyc(5'd16, 1'b1, 1'b0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_sv", int'(sample_valid), 0);
        chk("stop_pending", int'(dut.pending_reg), 0);
        for (int k = 0; k < 6; k++) cyc(5'd0, 1'b0, 1'b1);
        chk("stop_still_idle", int'(busy), 0);
        chk("stop_no_done", done_cnt, 0);

        // Request on the final strobe: done, full gap, then the new clip
        cyc(5'd8, 1'b0, 1'b0);
        cyc(5'd0, 1'b0, 1'b0);
        cyc(5'd0, 1'b0, 1'b0);
        strobes(3);
        chk("end_addr3", int'(addr), 3);
        cyc(5'd8, 1'b0, 1'b1);
        chk("end_done", int'(done), 1);
        chk("end_gap_sv", int'(sample_valid), 0);
        strobes(1);
        chk("end_gap1_busy", int'(busy), 1);
        chk("end_gap1_sv", int'(sample_valid), 0);
        strobes(1);
        chk("end_gap2_sv", int'(sample_valid), 0);
        cyc(5'd0, 1'b0, 1'b0);
        chk("end_replay_sv", int'(sample_valid), 1);
        chk("end_replay_addr", int'(addr), 0);

        // Reset mid-PLAY with a request pending
        strobes(1);
        cyc(5'd16, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(5'd4, 1'b0, 1'b1);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_sv", int'(sample_valid), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_addr", int'(addr), 0);
        chk("mrst_type", int'(sound_type), int'(SOUND_LOADING));
        chk("mrst_pending", int'(dut.pending_reg), 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cyc(5'd0, 1'b0, 1'b1);
        chk("mrst_stays_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
